// File: rtl/mips_pkg.sv
// Shared definitions for the back half of the MIPS pipeline.
//  - DATA_W / REG_AW / CNT_W : default datapath, register-address and counter widths
//  - ctrl_m_t : control bits carried from EX into MEM
//  - ctrl_w_t : control bits carried from MEM into WB
//  - to_ctrl_w : extracts the WB-relevant subset of a MEM control word
package mips_pkg;

   localparam int DATA_W = 32;
   localparam int REG_AW = 5;
   localparam int CNT_W  = 32;

   typedef struct packed {
      logic reg_write;
      logic mem_to_reg;
      logic mem_write;
      logic branch;
   } ctrl_m_t;

   typedef struct packed {
      logic reg_write;
      logic mem_to_reg;
   } ctrl_w_t;

   localparam int CTRL_M_W = $bits(ctrl_m_t);
   localparam int CTRL_W_W = $bits(ctrl_w_t);

   function automatic ctrl_w_t to_ctrl_w(input ctrl_m_t c);
      ctrl_w_t r;
      r.reg_write  = c.reg_write;
      r.mem_to_reg = c.mem_to_reg;
      return r;
   endfunction

endpackage

// File: rtl/pipe_reg_en.sv
// Generic pipeline register with a valid bit.
//  clk_i    : clock (posedge)
//  rst_ni   : asynchronous active-low reset, clears payload and valid
//  hold_i   : keep current payload and valid
//  vclr_i   : force valid to 0 (payload loads); wins over hold_i
//  valid_i  : incoming valid bit
//  d_i      : incoming payload
//  valid_o  : registered valid bit
//  q_o      : registered payload
module pipe_reg_en #(
   parameter int W = 8
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic         hold_i,
   input  logic         vclr_i,
   input  logic         valid_i,
   input  logic [W-1:0] d_i,
   output logic         valid_o,
   output logic [W-1:0] q_o
);

   logic [W-1:0] q_d, q_q;
   logic         valid_d, valid_q;

   // Next-state selection: clear-valid, then hold, then load.
   always_comb begin
      q_d     = q_q;
      valid_d = valid_q;
      if (vclr_i) begin
         q_d     = d_i;
         valid_d = 1'b0;
      end else if (hold_i) begin
         q_d     = q_q;
         valid_d = valid_q;
      end else begin
         q_d     = d_i;
         valid_d = valid_i;
      end
   end

   // State register with asynchronous clear.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         q_q     <= '0;
         valid_q <= 1'b0;
      end else begin
         q_q     <= q_d;
         valid_q <= valid_d;
      end
   end

   assign q_o     = q_q;
   assign valid_o = valid_q;

endmodule

// File: rtl/ex_mem_wb_pipe.sv
// EX/MEM and MEM/WB pipeline registers of a 5-stage MIPS pipeline.
//  Inputs : E-stage control (RegWriteE, MemToRegE, MemWriteE, BranchE, ValidE),
//           E-stage data (ZeroE, ALUOutE, WriteDataE, WriteRegE, PCBranchE),
//           FlushE (squash leaving EX), MemStall (hold MEM), ReadDataM (load data).
//  Outputs: M-stage memory/forwarding/branch signals (ALUOutM, WriteDataM, MemWriteM,
//           WriteRegM, RegWriteM, PCSrcM, PCBranchM, StallUp), W-stage write-back
//           (ResultW, WriteRegW, RegWriteW) and the retired-instruction count RetireCnt.
//  All control-type outputs are gated by the stage valid bit so bubbles are inert.
module ex_mem_wb_pipe #(
   parameter int DATA_W = 32,
   parameter int REG_AW = 5,
   parameter int CNT_W  = 32
) (
   input  logic              CLK,
   input  logic              RST_N,
   input  logic              RegWriteE,
   input  logic              MemToRegE,
   input  logic              MemWriteE,
   input  logic              BranchE,
   input  logic              ValidE,
   input  logic              ZeroE,
   input  logic [DATA_W-1:0] ALUOutE,
   input  logic [DATA_W-1:0] WriteDataE,
   input  logic [REG_AW-1:0] WriteRegE,
   input  logic [DATA_W-1:0] PCBranchE,
   input  logic              FlushE,
   input  logic              MemStall,
   input  logic [DATA_W-1:0] ReadDataM,
   output logic [DATA_W-1:0] ALUOutM,
   output logic [DATA_W-1:0] WriteDataM,
   output logic              MemWriteM,
   output logic [REG_AW-1:0] WriteRegM,
   output logic              RegWriteM,
   output logic              PCSrcM,
   output logic [DATA_W-1:0] PCBranchM,
   output logic              StallUp,
   output logic [DATA_W-1:0] ResultW,
   output logic [REG_AW-1:0] WriteRegW,
   output logic              RegWriteW,
   output logic [CNT_W-1:0]  RetireCnt
);

   import mips_pkg::*;

   localparam int EXM_W = CTRL_M_W + 1 + 3 * DATA_W + REG_AW;
   localparam int MWB_W = CTRL_W_W + 2 * DATA_W + REG_AW;

   // ---------------- EX/MEM ----------------
   ctrl_m_t           ctrl_e_s, ctrl_m_s;
   logic              zero_m_s, valid_m_s;
   logic [DATA_W-1:0] alu_m_s, wdata_m_s, pcb_m_s;
   logic [REG_AW-1:0] wreg_m_s;
   logic [EXM_W-1:0]  exm_d_s, exm_q_s;

   assign ctrl_e_s.reg_write  = RegWriteE;
   assign ctrl_e_s.mem_to_reg = MemToRegE;
   assign ctrl_e_s.mem_write  = MemWriteE;
   assign ctrl_e_s.branch     = BranchE;

   assign exm_d_s = {ctrl_e_s, ZeroE, ALUOutE, WriteDataE, PCBranchE, WriteRegE};
   assign {ctrl_m_s, zero_m_s, alu_m_s, wdata_m_s, pcb_m_s, wreg_m_s} = exm_q_s;

   // A stall outranks a flush: the hazard unit re-asserts FlushE until the stall clears.
   pipe_reg_en #(.W(EXM_W)) u_ex_mem (
      .clk_i   (CLK),
      .rst_ni  (RST_N),
      .hold_i  (MemStall),
      .vclr_i  (FlushE & ~MemStall),
      .valid_i (ValidE),
      .d_i     (exm_d_s),
      .valid_o (valid_m_s),
      .q_o     (exm_q_s)
   );

   // ---------------- MEM/WB ----------------
   ctrl_w_t           ctrl_w_s;
   logic              valid_w_s;
   logic [DATA_W-1:0] alu_w_s, rdata_w_s;
   logic [REG_AW-1:0] wreg_w_s;
   logic [MWB_W-1:0]  mwb_d_s, mwb_q_s;

   assign mwb_d_s = {to_ctrl_w(ctrl_m_s), alu_m_s, ReadDataM, wreg_m_s};
   assign {ctrl_w_s, alu_w_s, rdata_w_s, wreg_w_s} = mwb_q_s;

   // While MEM is stalled the load data is not valid, so a bubble enters WB.
   pipe_reg_en #(.W(MWB_W)) u_mem_wb (
      .clk_i   (CLK),
      .rst_ni  (RST_N),
      .hold_i  (1'b0),
      .vclr_i  (MemStall),
      .valid_i (valid_m_s),
      .d_i     (mwb_d_s),
      .valid_o (valid_w_s),
      .q_o     (mwb_q_s)
   );

   // ---------------- retire counter ----------------
   logic [CNT_W-1:0] cnt_d, cnt_q;

   // Count each valid instruction as it leaves WB; wraps naturally.
   always_comb begin
      cnt_d = cnt_q;
      if (valid_w_s) begin
         cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
         cnt_d = cnt_q;
      end
   end

   // Retire counter register.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // ---------------- outputs ----------------
   assign ALUOutM    = alu_m_s;
   assign WriteDataM = wdata_m_s;
   assign WriteRegM  = wreg_m_s;
   assign PCBranchM  = pcb_m_s;
   assign MemWriteM  = ctrl_m_s.mem_write & valid_m_s;
   assign RegWriteM  = ctrl_m_s.reg_write & valid_m_s;
   assign PCSrcM     = ctrl_m_s.branch & zero_m_s & valid_m_s;
   assign StallUp    = MemStall;
   assign ResultW    = ctrl_w_s.mem_to_reg ? rdata_w_s : alu_w_s;
   assign WriteRegW  = wreg_w_s;
   assign RegWriteW  = ctrl_w_s.reg_write & valid_w_s;
   assign RetireCnt  = cnt_q;

endmodule

// File: tb/tb_ex_mem_wb_pipe.sv
module tb_ex_mem_wb_pipe;

   logic        CLK = 1'b0;
   logic        RST_N;
   logic        RegWriteE, MemToRegE, MemWriteE, BranchE, ValidE, ZeroE;
   logic [31:0] ALUOutE, WriteDataE, PCBranchE, ReadDataM;
   logic [4:0]  WriteRegE;
   logic        FlushE, MemStall;

   logic [31:0] ALUOutM, WriteDataM, PCBranchM, ResultW, RetireCnt;
   logic        MemWriteM, RegWriteM, PCSrcM, StallUp, RegWriteW;
   logic [4:0]  WriteRegM, WriteRegW;

   logic [31:0] ALUOutM4, WriteDataM4, PCBranchM4, ResultW4;
   logic        MemWriteM4, RegWriteM4, PCSrcM4, StallUp4, RegWriteW4;
   logic [4:0]  WriteRegM4, WriteRegW4;
   logic [3:0]  RetireCnt4;

   always #5 CLK = ~CLK;

   ex_mem_wb_pipe dut (
      .CLK(CLK), .RST_N(RST_N), .RegWriteE(RegWriteE), .MemToRegE(MemToRegE),
      .MemWriteE(MemWriteE), .BranchE(BranchE), .ValidE(ValidE), .ZeroE(ZeroE),
      .ALUOutE(ALUOutE), .WriteDataE(WriteDataE), .WriteRegE(WriteRegE),
      .PCBranchE(PCBranchE), .FlushE(FlushE), .MemStall(MemStall), .ReadDataM(ReadDataM),
      .ALUOutM(ALUOutM), .WriteDataM(WriteDataM), .MemWriteM(MemWriteM),
      .WriteRegM(WriteRegM), .RegWriteM(RegWriteM), .PCSrcM(PCSrcM), .PCBranchM(PCBranchM),
      .StallUp(StallUp), .ResultW(ResultW), .WriteRegW(WriteRegW), .RegWriteW(RegWriteW),
      .RetireCnt(RetireCnt)
   );

   // Shortened-counter build used for the wrap check.
   ex_mem_wb_pipe #(.CNT_W(4)) dut4 (
      .CLK(CLK), .RST_N(RST_N), .RegWriteE(RegWriteE), .MemToRegE(MemToRegE),
      .MemWriteE(MemWriteE), .BranchE(BranchE), .ValidE(ValidE), .ZeroE(ZeroE),
      .ALUOutE(ALUOutE), .WriteDataE(WriteDataE), .WriteRegE(WriteRegE),
      .PCBranchE(PCBranchE), .FlushE(FlushE), .MemStall(MemStall), .ReadDataM(ReadDataM),
      .ALUOutM(ALUOutM4), .WriteDataM(WriteDataM4), .MemWriteM(MemWriteM4),
      .WriteRegM(WriteRegM4), .RegWriteM(RegWriteM4), .PCSrcM(PCSrcM4), .PCBranchM(PCBranchM4),
      .StallUp(StallUp4), .ResultW(ResultW4), .WriteRegW(WriteRegW4), .RegWriteW(RegWriteW4),
      .RetireCnt(RetireCnt4)
   );

   // Reference model: the instruction occupying each stage, as the spec describes it.
   typedef struct {
      bit          valid, rw, m2r, mw, br, z;
      logic [31:0] alu, wd, pcb;
      logic [4:0]  wr;
   } m_instr_t;

   typedef struct {
      bit          valid, rw, m2r;
      logic [31:0] alu, rd;
      logic [4:0]  wr;
   } w_instr_t;

   m_instr_t    m_st;
   w_instr_t    w_st;
   logic [31:0] retired;

   int n_assert = 0;
   int n_fail   = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_st = '{default: '0};
      w_st = '{default: '0};
      retired = 32'd0;
   endtask

   task automatic check_all();
      logic [31:0] res;
      res = w_st.m2r ? w_st.rd : w_st.alu;
      chk("StallUp",   StallUp,   MemStall);
      chk("MemWriteM", MemWriteM, m_st.valid & m_st.mw);
      chk("RegWriteM", RegWriteM, m_st.valid & m_st.rw);
      chk("PCSrcM",    PCSrcM,    m_st.valid & m_st.br & m_st.z);
      chk("RegWriteW", RegWriteW, w_st.valid & w_st.rw);
      chk("RetireCnt", RetireCnt, retired);
      chk("RetireCnt4", RetireCnt4, retired[3:0]);
      chk("PCSrcM4",   PCSrcM4,   m_st.valid & m_st.br & m_st.z);
      chk("MemWriteM4", MemWriteM4, m_st.valid & m_st.mw);
      chk("RegWriteM4", RegWriteM4, m_st.valid & m_st.rw);
      chk("RegWriteW4", RegWriteW4, w_st.valid & w_st.rw);
      chk("StallUp4",  StallUp4,  MemStall);
      if (m_st.valid) begin
         chk("ALUOutM",    ALUOutM,    m_st.alu);
         chk("WriteDataM", WriteDataM, m_st.wd);
         chk("WriteRegM",  WriteRegM,  m_st.wr);
         chk("PCBranchM",  PCBranchM,  m_st.pcb);
         chk("ALUOutM4",   ALUOutM4,   m_st.alu);
         chk("WriteDataM4", WriteDataM4, m_st.wd);
         chk("WriteRegM4", WriteRegM4, m_st.wr);
         chk("PCBranchM4", PCBranchM4, m_st.pcb);
      end
      if (w_st.valid) begin
         chk("ResultW",   ResultW,   res);
         chk("WriteRegW", WriteRegW, w_st.wr);
         chk("ResultW4",  ResultW4,  res);
         chk("WriteRegW4", WriteRegW4, w_st.wr);
      end
   endtask

   // One clock: advance the model from the current inputs, then check after the edge.
   task automatic clk_step();
      m_instr_t    nm;
      w_instr_t    nw;
      logic [31:0] nr;
      nr = retired + (w_st.valid ? 32'd1 : 32'd0);
      nw = w_st;
      if (MemStall) nw.valid = 1'b0;
      else begin
         nw.valid = m_st.valid; nw.rw = m_st.rw; nw.m2r = m_st.m2r;
         nw.alu = m_st.alu; nw.rd = ReadDataM; nw.wr = m_st.wr;
      end
      nm = m_st;
      if (!MemStall) begin
         nm.valid = FlushE ? 1'b0 : ValidE;
         nm.rw = RegWriteE; nm.m2r = MemToRegE; nm.mw = MemWriteE; nm.br = BranchE;
         nm.z = ZeroE; nm.alu = ALUOutE; nm.wd = WriteDataE; nm.pcb = PCBranchE;
         nm.wr = WriteRegE;
      end
      @(posedge CLK);
      #1;
      m_st = nm; w_st = nw; retired = nr;
      check_all();
   endtask

   task automatic set_bubble();
      RegWriteE = 1'b0; MemToRegE = 1'b0; MemWriteE = 1'b0; BranchE = 1'b0;
      ValidE = 1'b0; ZeroE = 1'b0; ALUOutE = 32'h0; WriteDataE = 32'h0;
      WriteRegE = 5'd0; PCBranchE = 32'h0; FlushE = 1'b0;
   endtask

   task automatic set_instr(input bit rw, input bit m2r, input bit mw, input bit br,
                            input bit z, input logic [31:0] alu, input logic [4:0] wr);
      RegWriteE = rw; MemToRegE = m2r; MemWriteE = mw; BranchE = br; ZeroE = z;
      ValidE = 1'b1; ALUOutE = alu; WriteRegE = wr; WriteDataE = alu ^ 32'hA5A5_0000;
      PCBranchE = alu + 32'h4; FlushE = 1'b0;
   endtask

   initial begin
      // ---- reset ----
      set_bubble();
      MemStall = 1'b0; ReadDataM = 32'h0;
      RST_N = 1'b0;
      model_reset();
      #7;
      check_all();
      chk("rst_ResultW", ResultW, 32'h0);
      chk("rst_ALUOutM", ALUOutM, 32'h0);
      @(negedge CLK);
      RST_N = 1'b1;

      // ---- counter wrap: 17 retirements, 4-bit build reads 1 ----
      for (int i = 0; i < 17; i++) begin
         set_instr(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'(i), 5'(i + 1));
         clk_step();
      end
      set_bubble();
      clk_step();
      clk_step();
      chk("wrap_cnt4", RetireCnt4, 4'd1);
      chk("wrap_cnt32", RetireCnt, 32'd17);

      // ---- 1: valid add ----
      RST_N = 1'b0; #1; model_reset(); @(negedge CLK); RST_N = 1'b1;
      set_instr(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h10, 5'd8);
      clk_step();
      chk("add_RegWriteM", RegWriteM, 1'b1);
      chk("add_WriteRegM", WriteRegM, 5'd8);
      set_bubble();
      clk_step();
      chk("add_RegWriteW", RegWriteW, 1'b1);
      chk("add_ResultW", ResultW, 32'h10);
      clk_step();
      chk("add_RetireCnt", RetireCnt, 32'd1);

      // ---- 2: lw, then lw with a 3-cycle stall ----
      set_instr(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h100, 5'd9);
      clk_step();
      set_bubble();
      ReadDataM = 32'hDEADBEEF;
      clk_step();
      chk("lw_ResultW", ResultW, 32'hDEADBEEF);
      set_instr(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h104, 5'd10);
      ReadDataM = 32'h0;
      clk_step();
      set_bubble();
      MemStall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         clk_step();
         chk("stall_ALUOutM", ALUOutM, 32'h104);
         chk("stall_RegWriteM", RegWriteM, 1'b1);
         chk("stall_StallUp", StallUp, 1'b1);
         chk("stall_RegWriteW", RegWriteW, 1'b0);
      end
      MemStall = 1'b0;
      ReadDataM = 32'hDEADBEEF;
      clk_step();
      chk("stall_ResultW", ResultW, 32'hDEADBEEF);
      chk("stall_RegWriteW_after", RegWriteW, 1'b1);

      // ---- 3: beq taken / not taken ----
      set_instr(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h3C, 5'd0);
      PCBranchE = 32'h40;
      clk_step();
      chk("beq_PCSrcM", PCSrcM, 1'b1);
      chk("beq_PCBranchM", PCBranchM, 32'h40);
      ZeroE = 1'b0;
      clk_step();
      chk("bne_PCSrcM", PCSrcM, 1'b0);

      // ---- 4: flushed store, then flush during a stall ----
      set_instr(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h200, 5'd0);
      FlushE = 1'b1;
      clk_step();
      chk("flush_MemWriteM", MemWriteM, 1'b0);
      FlushE = 1'b0;
      clk_step();
      chk("sw_MemWriteM", MemWriteM, 1'b1);
      set_instr(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h999, 5'd3);
      FlushE = 1'b1;
      MemStall = 1'b1;
      clk_step();
      chk("flushstall_MemWriteM", MemWriteM, 1'b1);
      chk("flushstall_ALUOutM", ALUOutM, 32'h200);

      // ---- 5: async reset while the store is stalled ----
      #2 RST_N = 1'b0;
      #1;
      chk("arst_MemWriteM", MemWriteM, 1'b0);
      chk("arst_PCSrcM", PCSrcM, 1'b0);
      chk("arst_RegWriteW", RegWriteW, 1'b0);
      chk("arst_RetireCnt", RetireCnt, 32'd0);
      model_reset();
      #1 RST_N = 1'b1;
      MemStall = 1'b0;
      set_instr(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h77, 5'd4);
      clk_step();
      set_bubble();
      clk_step();
      chk("post_rst_ResultW", ResultW, 32'h77);
      clk_step();
      chk("post_rst_RetireCnt", RetireCnt, 32'd1);

      // ---- random traffic against the model ----
      for (int i = 0; i < 400; i++) begin
         RegWriteE  = 1'($urandom);
         MemToRegE  = 1'($urandom);
         MemWriteE  = 1'($urandom);
         BranchE    = 1'($urandom);
         ZeroE      = 1'($urandom);
         ValidE     = ($urandom_range(0, 3) != 0);
         ALUOutE    = $urandom;
         WriteDataE = $urandom;
         PCBranchE  = $urandom;
         WriteRegE  = 5'($urandom);
         FlushE     = ($urandom_range(0, 5) == 0);
         MemStall   = ($urandom_range(0, 3) == 0);
         ReadDataM  = $urandom;
         clk_step();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
